// File: rtl/ldm_pkg.sv
// Shared constants and types for the LED dot matrix (LDM) scan controller.
// Holds the matrix geometry and the row-scan FSM state encoding.
package ldm_pkg;

    localparam int unsigned LDM_ROWS   = 16;
    localparam int unsigned LDM_COLS   = 16;
    localparam int unsigned LDM_ADDR_W = 4;

    // Row-scan FSM encoding
    localparam logic [1:0] LDM_ST_BLANK = 2'd0;
    localparam logic [1:0] LDM_ST_LOAD  = 2'd1;
    localparam logic [1:0] LDM_ST_SHOW  = 2'd2;

    typedef enum logic [1:0] {
        StBlank = LDM_ST_BLANK,
        StLoad  = LDM_ST_LOAD,
        StShow  = LDM_ST_SHOW
    } ldm_state_e;

    typedef logic [LDM_COLS-1:0] ldm_row_t;

endpackage

// File: rtl/ldm_prescaler.sv
// Scan-tick prescaler for the LDM controller.
// Divides clk by CLK_DIV to produce a one-cycle scan tick. It also produces
// ldm_clk, which toggles on every tick, giving a period of 2*CLK_DIV clk.
//
// Ports:
//   clk      in   system clock
//   rstn     in   asynchronous active-low reset
//   tick     out  one-cycle strobe, high when the divider reaches CLK_DIV-1
//   ldm_clk  out  registered scan clock toward the matrix drivers
module ldm_prescaler #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rstn,
    output logic tick,
    output logic ldm_clk
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt_q, div_cnt_d;
    logic       ldm_clk_q, ldm_clk_d;

    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? 8'd0 : div_cnt_q + 8'd1;
        ldm_clk_d = ldm_clk_q ^ tick;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt_q <= 8'd0;
            ldm_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            ldm_clk_q <= ldm_clk_d;
        end
    end

    assign ldm_clk = ldm_clk_q;

endmodule

// File: rtl/ldm_scan_ctrl.sv
// Row-scan controller for the 16x16 LED dot matrix.
// Keeps a double-buffered frame store: the front buffer is scanned out to the
// matrix, and the back buffer is written by the host. A host swap request is
// honoured only at the frame boundary, so a frame is never torn.
//
// Each row runs BLANK (BLANK_TICKS ticks, enable low) -> LOAD (1 tick, address
// and data latched, enable low) -> SHOW (DWELL_TICKS ticks, enable high).
//
// Ports:
//   clk          in   system clock
//   rstn         in   asynchronous active-low reset
//   wr_en        in   write one back-buffer row this cycle
//   wr_addr      in   row index for the write
//   wr_data      in   column pattern for the write (bit i = column i)
//   swap_req     in   level swap request, held until swap_ack
//   swap_ack     out  one-cycle pulse when the swap is performed
//   ldm_clk      out  scan clock
//   ldm_addr_en  out  row enable, high only while a row is shown
//   ldm_addr     out  current row address
//   ldm_data     out  column data of the current row (front buffer)
//   frame_done   out  one-cycle pulse after row 15 finishes
module ldm_scan_ctrl
    import ldm_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned BLANK_TICKS = 2,
    parameter int unsigned DWELL_TICKS = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [LDM_ADDR_W-1:0] wr_addr,
    input  logic [LDM_COLS-1:0]   wr_data,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic                  ldm_clk,
    output logic                  ldm_addr_en,
    output logic [LDM_ADDR_W-1:0] ldm_addr,
    output logic [LDM_COLS-1:0]   ldm_data,
    output logic                  frame_done
);

    localparam logic [7:0]            BLANK_LAST = 8'(BLANK_TICKS - 1);
    localparam logic [7:0]            DWELL_LAST = 8'(DWELL_TICKS - 1);
    localparam logic [LDM_ADDR_W-1:0] ROW_LAST   = LDM_ADDR_W'(LDM_ROWS - 1);

    logic tick;

    ldm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .rstn    (rstn),
        .tick    (tick),
        .ldm_clk (ldm_clk)
    );

    // Frame store: frame_q[front_q] is displayed, the other buffer is host-writable.
    ldm_row_t frame_q [2][LDM_ROWS];

    ldm_state_e            state_q, state_d;
    logic [7:0]            tick_cnt_q, tick_cnt_d;
    logic [LDM_ADDR_W-1:0] row_q, row_d;
    logic                  front_q, front_d;
    logic                  pending_q, pending_d;
    // armed_q is cleared by an ack and set again once swap_req is seen low,
    // so a request held across an ack cannot trigger a second swap.
    logic                  armed_q, armed_d;
    logic                  addr_en_q, addr_en_d;
    logic [LDM_ADDR_W-1:0] addr_q, addr_d;
    ldm_row_t              data_q, data_d;
    logic                  frame_done_q, frame_done_d;
    logic                  swap_ack_q, swap_ack_d;

    logic                  boundary;
    logic                  req_new;

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        row_d        = row_q;
        front_d      = front_q;
        pending_d    = pending_q;
        armed_d      = armed_q;
        addr_en_d    = addr_en_q;
        addr_d       = addr_q;
        data_d       = data_q;
        frame_done_d = 1'b0;
        swap_ack_d   = 1'b0;
        boundary     = 1'b0;
        req_new      = swap_req & armed_q;

        if (tick) begin
            unique case (state_q)
                StBlank: begin
                    if (tick_cnt_q == BLANK_LAST) begin
                        state_d    = StLoad;
                        tick_cnt_d = 8'd0;
                        // Latch address/data on entry to LOAD so they are stable for
                        // the whole LOAD tick before the enable rises.
                        addr_d     = row_q;
                        data_d     = frame_q[front_q][row_q];
                    end else begin
                        tick_cnt_d = tick_cnt_q + 8'd1;
                    end
                end
                StLoad: begin
                    state_d    = StShow;
                    tick_cnt_d = 8'd0;
                    addr_en_d  = 1'b1;
                end
                StShow: begin
                    if (tick_cnt_q == DWELL_LAST) begin
                        state_d    = StBlank;
                        tick_cnt_d = 8'd0;
                        addr_en_d  = 1'b0;
                        row_d      = row_q + 1'b1;
                        boundary   = (row_q == ROW_LAST);
                    end else begin
                        tick_cnt_d = tick_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d    = StBlank;
                    tick_cnt_d = 8'd0;
                end
            endcase
        end

        frame_done_d = boundary;

        if (boundary && (pending_q || req_new)) begin
            front_d    = ~front_q;
            swap_ack_d = 1'b1;
            pending_d  = 1'b0;
            armed_d    = 1'b0;
        end else begin
            if (req_new) begin
                pending_d = 1'b1;
            end
            if (!swap_req) begin
                armed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StBlank;
            tick_cnt_q   <= 8'd0;
            row_q        <= '0;
            front_q      <= 1'b0;
            pending_q    <= 1'b0;
            armed_q      <= 1'b1;
            addr_en_q    <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
            swap_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            row_q        <= row_d;
            front_q      <= front_d;
            pending_q    <= pending_d;
            armed_q      <= armed_d;
            addr_en_q    <= addr_en_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            swap_ack_q   <= swap_ack_d;
        end
    end

    // Writes use the pre-edge front select, so a write in the swap cycle lands in
    // the buffer that becomes front, and the displayed buffer is never touched.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < LDM_ROWS; r++) begin
                    frame_q[b][r] <= '0;
                end
            end
        end else if (wr_en) begin
            frame_q[~front_q][wr_addr] <= wr_data;
        end
    end

    assign swap_ack    = swap_ack_q;
    assign ldm_addr_en = addr_en_q;
    assign ldm_addr    = addr_q;
    assign ldm_data    = data_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_ldm_scan_ctrl.sv
module tb_ldm_scan_ctrl;

    localparam int D       = 4;
    localparam int B       = 2;
    localparam int W       = 8;
    localparam int P       = B + 1 + W;
    localparam int FRAME_T = 16 * P;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        swap_req;
    logic        swap_ack, ldm_clk, ldm_addr_en, frame_done;
    logic [3:0]  ldm_addr;
    logic [15:0] ldm_data;

    // Second instance with the minimal timing parameters, inputs idle.
    logic        b_wr_en    = 1'b0;
    logic [3:0]  b_wr_addr  = 4'd0;
    logic [15:0] b_wr_data  = 16'd0;
    logic        b_swap_req = 1'b0;
    logic        b_swap_ack, b_ldm_clk, b_ldm_addr_en, b_frame_done;
    logic [3:0]  b_ldm_addr;
    logic [15:0] b_ldm_data;

    ldm_scan_ctrl #(
        .CLK_DIV     (D),
        .BLANK_TICKS (B),
        .DWELL_TICKS (W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .ldm_clk     (ldm_clk),
        .ldm_addr_en (ldm_addr_en),
        .ldm_addr    (ldm_addr),
        .ldm_data    (ldm_data),
        .frame_done  (frame_done)
    );

    ldm_scan_ctrl #(
        .CLK_DIV     (2),
        .BLANK_TICKS (1),
        .DWELL_TICKS (1)
    ) dut_b (
        .clk         (clk),
        .rstn        (rstn),
        .wr_en       (b_wr_en),
        .wr_addr     (b_wr_addr),
        .wr_data     (b_wr_data),
        .swap_req    (b_swap_req),
        .swap_ack    (b_swap_ack),
        .ldm_clk     (b_ldm_clk),
        .ldm_addr_en (b_ldm_addr_en),
        .ldm_addr    (b_ldm_addr),
        .ldm_data    (b_ldm_data),
        .frame_done  (b_frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: outputs derived from elapsed ticks since reset release.
    int          cyc;
    int          front;
    logic [15:0] mem [2][16];
    bit          pending, armed;
    logic        m_ack, m_fd, m_en, m_clk;
    logic [3:0]  m_addr;
    logic [15:0] m_data;

    task automatic model_reset();
        cyc = 0; front = 0; pending = 0; armed = 1;
        m_ack = 0; m_fd = 0; m_en = 0; m_clk = 0; m_addr = 0; m_data = 0;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 16; r++)
                mem[b][r] = 16'd0;
    endtask

    initial begin
        int  t;
        bit  tk, bnd, req_now;
        model_reset();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                model_reset();
            end else begin
                cyc++;
                tk  = (cyc % D) == 0;
                t   = cyc / D;
                bnd = tk && (t % FRAME_T) == 0;
                if (tk && (t % P) == B) begin
                    m_addr = 4'((t / P) % 16);
                    m_data = mem[front][(t / P) % 16];
                end
                if (wr_en) mem[1 - front][wr_addr] = wr_data;
                req_now = swap_req && armed;
                m_ack = 0;
                if (bnd && (pending || req_now)) begin
                    front = 1 - front; m_ack = 1; pending = 0; armed = 0;
                end else begin
                    if (req_now) pending = 1;
                    if (!swap_req) armed = 1;
                end
                m_fd  = bnd;
                m_en  = (t % P) >= (B + 1);
                m_clk = t[0];
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cmp swap_ack", swap_ack, m_ack);
            check("cmp frame_done", frame_done, m_fd);
            check("cmp ldm_addr_en", ldm_addr_en, m_en);
            check("cmp ldm_clk", ldm_clk, m_clk);
            check("cmp ldm_addr", ldm_addr, m_addr);
            check("cmp ldm_data", ldm_data, m_data);
        end
    end

    task automatic go_to(input int n);
        int guard = 0;
        while (cyc < n) begin
            @(negedge clk);
            guard++;
            if (guard > 20000) begin
                $display("FAIL go_to timeout: got cycle %0d expected %0d", cyc, n);
                $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " swap_ack"}, swap_ack, 0);
        check({tag, " frame_done"}, frame_done, 0);
        check({tag, " ldm_addr_en"}, ldm_addr_en, 0);
        check({tag, " ldm_clk"}, ldm_clk, 0);
        check({tag, " ldm_addr"}, ldm_addr, 0);
        check({tag, " ldm_data"}, ldm_data, 0);
        check({tag, " b_ldm_addr_en"}, b_ldm_addr_en, 0);
        check({tag, " b_ldm_clk"}, b_ldm_clk, 0);
        check({tag, " b_frame_done"}, b_frame_done, 0);
    endtask

    initial begin
        wr_en = 0; wr_addr = 0; wr_data = 0; swap_req = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;

        // Frame 0: timing with defaults, front buffer all zero
        go_to(3);   check("clk c3", ldm_clk, 0);
        go_to(4);   check("clk c4", ldm_clk, 1);
        go_to(8);   check("clk c8", ldm_clk, 0); check("en c8", ldm_addr_en, 0);
                    check("addr c8", ldm_addr, 0);
        go_to(11);  check("en c11", ldm_addr_en, 0);
        go_to(12);  check("en c12", ldm_addr_en, 1);
        go_to(43);  check("en c43", ldm_addr_en, 1);
        go_to(44);  check("en c44", ldm_addr_en, 0);
        go_to(52);  check("addr c52", ldm_addr, 1);
        go_to(56);  check("en c56", ldm_addr_en, 1);
        for (int r = 0; r < 16; r++) begin
            go_to(100 + r);
            wr_en = 1; wr_addr = 4'(r); wr_data = 16'h0001 << r;
        end
        go_to(116); wr_en = 0;
        go_to(240); check("f0 row5 data", ldm_data, 16'h0000); check("f0 row5 addr", ldm_addr, 5);
        go_to(300); swap_req = 1;
        go_to(703); check("fd c703", frame_done, 0); check("ack c703", swap_ack, 0);
        go_to(704); check("fd c704", frame_done, 1); check("ack c704", swap_ack, 1);
                    swap_req = 0;
        go_to(705); check("fd c705", frame_done, 0); check("ack c705", swap_ack, 0);

        // Frame 1..3: new front, back write must not disturb display
        go_to(710); wr_en = 1; wr_addr = 5; wr_data = 16'hFFFF;
        go_to(711); wr_en = 0;
        go_to(724);  check("f1 row0 data", ldm_data, 16'h0001);
        go_to(944);  check("f1 row5 data", ldm_data, 16'h0020);
        go_to(1384); check("f1 row15 data", ldm_data, 16'h8000);
        go_to(1648); check("f2 row5 data", ldm_data, 16'h0020);
        go_to(2352); check("f3 row5 data", ldm_data, 16'h0020);

        // One-clk swap pulse in frame 4 row 3
        go_to(2968); swap_req = 1;
        go_to(2969); swap_req = 0;
        go_to(3520); check("pulse ack", swap_ack, 1);
        go_to(3521); check("pulse ack end", swap_ack, 0);
        go_to(3540); check("f5 row0 data", ldm_data, 16'h0000);

        // Held request: one ack, none at the following boundary
        go_to(3600); swap_req = 1;
        go_to(3760); check("f5 row5 data", ldm_data, 16'hFFFF);
        go_to(4224); check("held ack", swap_ack, 1); check("held fd", frame_done, 1);
        go_to(4464); check("f6 row5 data", ldm_data, 16'h0020);
        go_to(4928); check("no re-ack", swap_ack, 0); check("fd c4928", frame_done, 1);
        go_to(5000); swap_req = 0;
        go_to(5100); swap_req = 1;

        // Write landing in the swap cycle
        go_to(5631); wr_en = 1; wr_addr = 0; wr_data = 16'hA5A5;
        go_to(5632); wr_en = 0; check("rearm ack", swap_ack, 1); swap_req = 0;
        go_to(5652); check("f8 row0 data", ldm_data, 16'hA5A5);
        go_to(5872); check("f8 row5 data", ldm_data, 16'hFFFF);

        // Mid-frame reset in row 9 SHOW
        go_to(6048); check("pre-rst en", ldm_addr_en, 1); check("pre-rst addr", ldm_addr, 9);
        #2 rstn = 1'b0;
        #1 check_all_zero("async rst");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        go_to(2);   check("b clk c2", b_ldm_clk, 1);
        go_to(3);   check("b en c3", b_ldm_addr_en, 0);
        go_to(4);   check("b en c4", b_ldm_addr_en, 1); check("b clk c4", b_ldm_clk, 0);
        go_to(5);   check("b en c5", b_ldm_addr_en, 1);
        go_to(6);   check("b en c6", b_ldm_addr_en, 0);
        go_to(10);  check("b en c10", b_ldm_addr_en, 1); check("b addr c10", b_ldm_addr, 1);
        go_to(12);  check("rst row0 en", ldm_addr_en, 1);
        go_to(20);  check("rst row0 data", ldm_data, 0); check("rst row0 addr", ldm_addr, 0);
        go_to(94);  check("b en c94", b_ldm_addr_en, 1); check("b addr c94", b_ldm_addr, 15);
        go_to(96);  check("b fd c96", b_frame_done, 1); check("fd c96", frame_done, 0);
        go_to(98);  check("b addr c98", b_ldm_addr, 0);
        go_to(240); check("rst row5 data", ldm_data, 0); check("rst row5 addr", ldm_addr, 5);
        go_to(704); check("rst fd", frame_done, 1); check("rst no ack", swap_ack, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
